// File: rtl/uart_avm_arbiter_if.sv
// Avalon-MM master bundle between the requester arbiter and the RS232 UART.
// The arbiter uses the master modport; the UART (or a bench model) uses the slave one.
interface uart_avm_arbiter_if;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;

    modport master (
        output avm_address, avm_read, avm_write, avm_writedata,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_read, avm_write, avm_writedata,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/uart_avm_arbiter.sv
// Shares the UART Avalon-MM master between two byte requesters:
// req 0 = RSA key/ciphertext stream, req 1 = user/sight report sender.
// Each granted request polls STATUS until its ready bit is set, then does one
// RX read or TX write and pulses req_done to its owner. Round-robin by default;
// a poll-miss limit parks a stalled request so the other side is not starved.
// Optional macro ARB_FIXED_PRIO_EN: requester 0 always wins arbitration when
// valid (rr_ptr is then ignored).
module uart_avm_arbiter #(
    parameter int POLL_LIMIT  = 16,
    parameter int RX_BASE     = 0,
    parameter int TX_BASE     = 4,
    parameter int STATUS_BASE = 8,
    parameter int TX_OK_BIT   = 6,
    parameter int RX_OK_BIT   = 7
) (
    input  logic                      avm_clk,
    input  logic                      avm_rst,
    uart_avm_arbiter_if.master        avm,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [15:0]               req_wdata,
    output logic [1:0]                req_done,
    output logic [15:0]               req_rdata,
    output logic [1:0]                grant
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POLL = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [4:0] RX_ADDR     = 5'(RX_BASE);
    localparam logic [4:0] TX_ADDR     = 5'(TX_BASE);
    localparam logic [4:0] STATUS_ADDR = 5'(STATUS_BASE);
    localparam logic [8:0] MISS_LAST   = 9'(POLL_LIMIT);

    logic [1:0]  state;
    logic        owner;      // requester currently holding the bus
    logic        rr_ptr;     // requester preferred at the next arbitration
    logic        wr_flag;    // latched direction of the granted request
    logic [7:0]  wr_byte;    // latched TX byte of the granted request
    logic [7:0]  miss_cnt;   // consecutive not-ready STATUS polls
    logic [4:0]  addr_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] wdata_q;

    logic        win;
    logic        ready_bit;
    logic        miss_last;

    assign avm.avm_address   = addr_q;
    assign avm.avm_read      = read_q;
    assign avm.avm_write     = write_q;
    assign avm.avm_writedata = wdata_q;

    // Pick the IDLE winner and decode the STATUS poll currently on the bus.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
`ifdef ARB_FIXED_PRIO_EN
        win = ~req_valid[0];
`else
        win = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
`endif
        ready_bit = wr_flag ? avm.avm_readdata[TX_OK_BIT] : avm.avm_readdata[RX_OK_BIT];
        miss_last = ({1'b0, miss_cnt} + 9'd1) >= MISS_LAST;
    end

    // Arbitration FSM: IDLE -> POLL (STATUS) -> DATA (RX/TX) -> DONE -> IDLE.
    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            rr_ptr    <= 1'b0;
            wr_flag   <= 1'b0;
            wr_byte   <= 8'h00;
            miss_cnt  <= 8'h00;
            addr_q    <= STATUS_ADDR;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= 32'h0;
            req_done  <= 2'b00;
            req_rdata <= 16'h0000;
            grant     <= 2'b00;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every decision sees pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        owner    <= win;
                        wr_flag  <= req_write[win];
                        wr_byte  <= win ? req_wdata[15:8] : req_wdata[7:0];
                        grant    <= win ? 2'b10 : 2'b01;
                        miss_cnt <= 8'h00;
                        read_q   <= 1'b1;
                        addr_q   <= STATUS_ADDR;
                        state    <= ST_POLL;
                    end
                end

                ST_POLL: begin
                    if (!avm.avm_waitrequest) begin
                        if (!req_valid[owner]) begin
                            // Owner withdrew: drop the bus without done, keep rr_ptr.
                            read_q   <= 1'b0;
                            grant    <= 2'b00;
                            miss_cnt <= 8'h00;
                            state    <= ST_IDLE;
                        end else if (ready_bit) begin
                            miss_cnt <= 8'h00;
                            state    <= ST_DATA;
                            if (wr_flag) begin
                                read_q  <= 1'b0;
                                write_q <= 1'b1;
                                addr_q  <= TX_ADDR;
                                wdata_q <= {24'h0, wr_byte};
                            end else begin
                                addr_q  <= RX_ADDR;
                            end
                        end else if (miss_last) begin
                            // Park the stalled request and hand preference to the other side.
                            read_q   <= 1'b0;
                            grant    <= 2'b00;
                            miss_cnt <= 8'h00;
                            rr_ptr   <= ~owner;
                            state    <= ST_IDLE;
                        end else begin
                            miss_cnt <= miss_cnt + 8'd1;
                        end
                    end
                end

                ST_DATA: begin
                    if (!avm.avm_waitrequest) begin
                        if (!wr_flag) begin
                            if (owner) req_rdata[15:8] <= avm.avm_readdata[7:0];
                            else       req_rdata[7:0]  <= avm.avm_readdata[7:0];
                        end
                        read_q   <= 1'b0;
                        write_q  <= 1'b0;
                        addr_q   <= STATUS_ADDR;
                        req_done <= owner ? 2'b10 : 2'b01;
                        state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    req_done <= 2'b00;
                    grant    <= 2'b00;
                    rr_ptr   <= ~owner;
                    state    <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Self-checking bench for uart_avm_arbiter (default round-robin build).
// A small UART model answers STATUS polls from threshold counters, returns a
// programmable RX byte and stretches data accesses with waitrequest.
module tb_uart_avm_arbiter;

    localparam int NEVER = 32'h7fff_ffff;

    logic        avm_clk   = 1'b0;
    logic        avm_rst   = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_write = 2'b00;
    logic [15:0] req_wdata = 16'h0000;
    logic [1:0]  req_done;
    logic [15:0] req_rdata;
    logic [1:0]  grant;

    uart_avm_arbiter_if bus();

    uart_avm_arbiter #(.POLL_LIMIT(16)) dut (
        .avm_clk   (avm_clk),
        .avm_rst   (avm_rst),
        .avm       (bus.master),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .grant     (grant)
    );

    always #5 avm_clk = ~avm_clk;

    // UART model state: counters advanced by accepted bus cycles.
    int polls_seen = 0, wait_used = 0, rx_reads = 0, tx_writes = 0, both_high = 0;
    int rx_ok_at = 0, tx_ok_at = 0, data_wait_target = 0;
    logic [7:0] rx_byte = 8'h00;
    logic rx_lvl, tx_lvl;

    assign rx_lvl = (polls_seen >= rx_ok_at);
    assign tx_lvl = (polls_seen >= tx_ok_at);
    assign bus.avm_readdata = (bus.avm_address == 5'd8) ? {24'h0, rx_lvl, tx_lvl, 6'h00} :
                              (bus.avm_address == 5'd0) ? {24'h0, rx_byte} : 32'h0;
    assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (bus.avm_address != 5'd8) &&
                                 (wait_used < data_wait_target);

    always @(posedge avm_clk) begin
        if (bus.avm_read && !bus.avm_waitrequest && bus.avm_address == 5'd8) polls_seen <= polls_seen + 1;
        if (bus.avm_read && !bus.avm_waitrequest && bus.avm_address == 5'd0) rx_reads <= rx_reads + 1;
        if (bus.avm_write && !bus.avm_waitrequest && bus.avm_address == 5'd4) tx_writes <= tx_writes + 1;
        if (bus.avm_waitrequest) wait_used <= wait_used + 1;
        if (bus.avm_read && bus.avm_write) both_high <= both_high + 1;
    end

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Single-transaction vectors; latency = 3 + miss + dwait edges until done is seen.
    typedef struct {
        int         id;
        logic       wr;
        logic [7:0] wbyte;
        int         miss;
        logic [7:0] rxb;
        int         dwait;
        int         exp_polls;
        int         exp_lat;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t       vecs [6];
    vec_t       v;
    logic [7:0] model_rd [2];
    int lat, p0, r0, t0, n_done, last_cyc, done0_cyc, done1_cyc, n_stall, n_bad, found;
    int order [4];

    initial begin
        //          id wr    wbyte  miss rxb    dwait polls lat exp
        vecs[0] = '{0, 1'b0, 8'h00, 0,   8'h5A, 0,    1,    3,  8'h5A};
        vecs[1] = '{1, 1'b1, 8'hC3, 3,   8'h00, 0,    4,    6,  8'hC3};
        vecs[2] = '{1, 1'b0, 8'h00, 0,   8'hA7, 2,    1,    5,  8'hA7};
        vecs[3] = '{0, 1'b1, 8'h01, 15,  8'h00, 0,    16,   18, 8'h01};
        vecs[4] = '{0, 1'b0, 8'h00, 2,   8'hFF, 1,    3,    6,  8'hFF};
        vecs[5] = '{1, 1'b1, 8'h80, 0,   8'h00, 0,    1,    3,  8'h80};
        model_rd[0] = 8'h00;
        model_rd[1] = 8'h00;

        // Reset values
        repeat (2) @(negedge avm_clk);
        check("rst_read",   {31'h0, bus.avm_read}, 32'h0);
        check("rst_write",  {31'h0, bus.avm_write}, 32'h0);
        check("rst_addr",   {27'h0, bus.avm_address}, 32'h8);
        check("rst_wdata",  bus.avm_writedata, 32'h0);
        check("rst_grant",  {30'h0, grant}, 32'h0);
        check("rst_done",   {30'h0, req_done}, 32'h0);
        check("rst_rdata",  {16'h0, req_rdata}, 32'h0);
        avm_rst = 1'b0;
        repeat (2) @(negedge avm_clk);
        check("idle_grant", {30'h0, grant}, 32'h0);
        check("idle_polls", polls_seen, 0);

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            v  = vecs[i];
            p0 = polls_seen;
            r0 = rx_reads;
            t0 = tx_writes;
            rx_byte = v.rxb;
            if (v.wr) begin
                tx_ok_at = polls_seen + v.miss;
                rx_ok_at = 0;
            end else begin
                rx_ok_at = polls_seen + v.miss;
                tx_ok_at = 0;
            end
            data_wait_target = wait_used + v.dwait;
            req_write[v.id] = v.wr;
            req_wdata[8*v.id +: 8] = v.wbyte;
            req_valid[v.id] = 1'b1;
            lat = -1;
            for (int c = 1; c <= 64; c++) begin
                @(negedge avm_clk);
                if (c == 1) check($sformatf("v%0d_grant", i), {30'h0, grant}, (v.id != 0) ? 32'h2 : 32'h1);
                if (req_done[v.id]) begin
                    lat = c;
                    break;
                end
            end
            req_valid = 2'b00;
            check($sformatf("v%0d_lat", i), lat, v.exp_lat);
            check($sformatf("v%0d_polls", i), polls_seen - p0, v.exp_polls);
            if (v.wr) begin
                check($sformatf("v%0d_nwr", i), tx_writes - t0, 1);
                check($sformatf("v%0d_nrd", i), rx_reads - r0, 0);
                check($sformatf("v%0d_wdata", i), bus.avm_writedata, {24'h0, v.exp_byte});
            end else begin
                check($sformatf("v%0d_nrd", i), rx_reads - r0, 1);
                check($sformatf("v%0d_nwr", i), tx_writes - t0, 0);
                model_rd[v.id] = v.exp_byte;
            end
            check($sformatf("v%0d_rdata", i), {16'h0, req_rdata}, {16'h0, model_rd[1], model_rd[0]});
            @(negedge avm_clk);
            check($sformatf("v%0d_after", i), {28'h0, req_done, grant}, 32'h0);
        end

        // Both valid continuously: completions alternate 0,1,0,1 every 4 cycles
        rx_byte = 8'h11; rx_ok_at = 0; tx_ok_at = 0; data_wait_target = wait_used;
        req_write = 2'b10; req_wdata = 16'h2200; req_valid = 2'b11;
        n_done = 0; last_cyc = -1;
        for (int c = 1; c <= 40 && n_done < 4; c++) begin
            @(negedge avm_clk);
            if (req_done[0] && n_done < 4) begin order[n_done] = 0; n_done++; last_cyc = c; end
            if (req_done[1] && n_done < 4) begin order[n_done] = 1; n_done++; last_cyc = c; end
            if (n_done == 4) req_valid = 2'b00;
        end
        req_valid = 2'b00;
        check("rr_count", n_done, 4);
        for (int k = 0; k < 4; k++) check($sformatf("rr_order%0d", k), order[k], k % 2);
        check("rr_last_cyc", last_cyc, 15);
        @(negedge avm_clk);

        // Poll-miss limit: req0 RX stuck, req1 TX ready
        rx_byte = 8'h99; rx_ok_at = NEVER; tx_ok_at = 0;
        req_write = 2'b10; req_wdata = 16'h5500; req_valid = 2'b11;
        done0_cyc = -1; done1_cyc = -1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge avm_clk);
            if (c == 16) check("park_grant_before", {30'h0, grant}, 32'h1);
            if (c == 17) check("park_grant_after", {30'h0, grant}, 32'h0);
            if (req_done[1] && done1_cyc < 0) begin
                done1_cyc = c;
                rx_ok_at  = polls_seen + 2;
                check("park_wdata", bus.avm_writedata, 32'h55);
            end
            if (req_done[0]) begin
                done0_cyc = c;
                break;
            end
        end
        req_valid = 2'b00;
        check("park_done1_cyc", done1_cyc, 20);
        check("park_done0_cyc", done0_cyc, 26);
        check("park_rdata0", {24'h0, req_rdata[7:0]}, 32'h99);
        @(negedge avm_clk);

        // Waitrequest held for 5 cycles during a TX data write
        rx_ok_at = 0; tx_ok_at = 0; data_wait_target = wait_used + 5;
        req_write = 2'b10; req_wdata = 16'h3C00; req_valid = 2'b10;
        n_stall = 0; lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge avm_clk);
            if (bus.avm_waitrequest) begin
                n_stall++;
                check("hold_ctl", {25'h0, bus.avm_write, bus.avm_read, bus.avm_address}, 32'h44);
                check("hold_data", bus.avm_writedata, 32'h3C);
            end
            if (req_done[1]) begin
                lat = c;
                break;
            end
        end
        req_valid = 2'b00;
        check("hold_cycles", n_stall, 5);
        check("hold_done_cyc", lat, 8);
        @(negedge avm_clk);

        // Abort during POLL: no done, rr_ptr (0) unchanged
        rx_ok_at = NEVER; req_write = 2'b00; req_valid = 2'b01;
        repeat (3) @(negedge avm_clk);
        req_valid = 2'b00;
        @(negedge avm_clk);
        check("abort_idle", {29'h0, grant, bus.avm_read}, 32'h0);
        n_bad = 0;
        repeat (3) begin
            @(negedge avm_clk);
            if (req_done != 2'b00) n_bad++;
        end
        check("abort_no_done", n_bad, 0);
        req_write = 2'b10; req_wdata = 16'h7700; tx_ok_at = 0; req_valid = 2'b11;
        @(negedge avm_clk);
        check("abort_rr_kept", {30'h0, grant}, 32'h1);

        // Reset while in DATA
        rx_ok_at = 0; data_wait_target = wait_used + 10;
        found = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge avm_clk);
            if (bus.avm_read && bus.avm_address == 5'd0) begin
                found = 1;
                break;
            end
        end
        check("rst_reach_data", found, 1);
        avm_rst = 1'b1;
        @(negedge avm_clk);
        check("mid_rst_ctl", {25'h0, bus.avm_write, bus.avm_read, bus.avm_address}, 32'h08);
        check("mid_rst_grant", {28'h0, grant, req_done}, 32'h0);
        check("mid_rst_data", {16'h0, req_rdata}, 32'h0);
        check("mid_rst_wdata", bus.avm_writedata, 32'h0);
        data_wait_target = wait_used;
        req_valid = 2'b10;
        avm_rst = 1'b0;
        @(negedge avm_clk);
        check("post_rst_grant", {30'h0, grant}, 32'h2);
        lat = -1;
        for (int c = 2; c <= 20; c++) begin
            @(negedge avm_clk);
            if (req_done[1]) begin
                lat = c;
                break;
            end
        end
        req_valid = 2'b00;
        check("post_rst_lat", lat, 3);
        check("post_rst_wdata", bus.avm_writedata, 32'h77);
        @(negedge avm_clk);
        check("never_rd_and_wr", both_high, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_avm_arbiter.md
Name: uart_avm_arbiter

Overview:
Shares the single Avalon-MM master port of the RS232 UART between two byte-level requesters: req 0 is the RSA key/ciphertext stream, req 1 is the user/sight report sender. For each granted request the block polls STATUS until the right ready bit is set, then does one RX read or TX write. It returns the byte or completion to the owning requester. Round-robin arbitration, plus a poll-miss limit so one stalled direction cannot starve the other.

Parameters:
POLL_LIMIT, 16, consecutive not-ready STATUS polls before the current request is parked and arbitration reopens (legal range 1..255)
RX_BASE, 0, Avalon address of the RX data register
TX_BASE, 4, Avalon address of the TX data register
STATUS_BASE, 8, Avalon address of the STATUS register
TX_OK_BIT, 6, STATUS bit index meaning TX can accept a byte
RX_OK_BIT, 7, STATUS bit index meaning RX holds a byte

Ports:
avm_clk  in  1  clock
avm_rst  in  1  reset, asynchronous, active-high
avm_address  out  5  Avalon address
avm_read  out  1  Avalon read strobe
avm_readdata  in  32  Avalon read data; bits [7:0] carry the RX byte
avm_write  out  1  Avalon write strobe
avm_writedata  out  32  equals {24'b0, latched byte}
avm_waitrequest  in  1  Avalon stall
req_valid  in  2  per-requester request pending
req_write  in  2  per requester: 1 = TX byte, 0 = RX byte
req_wdata  in  16  TX bytes; requester i uses [8i+7:8i]
req_done  out  2  one-cycle completion pulse per requester
req_rdata  out  16  RX byte per requester; valid on req_done, held until that requester's next req_done
grant  out  2  one-hot owner of the bus; 0 when idle

Behaviour:
- Reset values: avm_read=0, avm_write=0, avm_address=STATUS_BASE, avm_writedata=0, req_done=0, req_rdata=0, grant=0, rr_ptr=0, miss_cnt=0, state=IDLE.
- All outputs are registered.
- Requester rule: hold req_valid, req_write and its req_wdata byte stable until its req_done. Dropping req_valid early is an abort (see below).
- State IDLE:
  - If any req_valid bit is set, grant the winner and go to POLL.
  - Winner: the requester at rr_ptr if it is valid, otherwise the other one.
  - On grant: latch write flag and byte, set grant, drive avm_read=1 and avm_address=STATUS_BASE in the next cycle (1-cycle latency from valid to bus).
- State POLL: hold read/address while avm_waitrequest=1. When waitrequest=0, sample avm_readdata at TX_OK_BIT (write) or RX_OK_BIT (read):
  - Bit set: go to DATA and drive next cycle either avm_read=1 at RX_BASE, or avm_write=1 at TX_BASE with writedata = latched byte. Clear miss_cnt.
  - Bit clear and miss_cnt+1 < POLL_LIMIT: increment miss_cnt, stay in POLL, and issue a new poll back-to-back (read stays high).
  - Bit clear and miss_cnt+1 == POLL_LIMIT: park. Deassert read, grant=0, miss_cnt=0, rr_ptr = other requester, go to IDLE, no req_done. A still-valid parked requester is re-arbitrated normally.
- State DATA: hold strobe/address/data while waitrequest=1. When waitrequest=0:
  - For a read, capture avm_readdata[7:0] into that requester's req_rdata.
  - Go to DONE.
- State DONE (one cycle):
  - avm_read and avm_write are 0, avm_address=STATUS_BASE.
  - req_done[owner]=1.
  - grant=0, rr_ptr = other requester, go to IDLE.
- Minimum spacing: at most one transaction per requester per 4 cycles with zero waitstates.
- Simultaneous valids: rr_ptr decides the winner; completions alternate 0,1,0,1.
- Abort: if the owner's req_valid falls during POLL, finish the in-flight bus read, then go to IDLE with no done and rr_ptr unchanged. A fall during DATA is ignored; the transaction completes and done pulses.
- avm_read and avm_write are never high together.
- A new request is never accepted while the state is not IDLE.
- Reset mid-transaction: immediate return to reset values; the UART-side access is dropped.

Optional Feature:
ARB_FIXED_PRIO_EN:
- Defined: requester 0 always wins in IDLE when valid, and rr_ptr is unused.
- Defined: on park, requester 0 still has priority. If requester 0 is the one parked and still valid, it is re-granted at once, so POLL_LIMIT only bounds bus-occupancy bursts.
- Undefined: round-robin as described above.

Test Plan:
- Req0 RX only; STATUS reads 0x80 on the first poll, RX reads 0x5A, zero waitstates -> bus sequence read@8, read@0, idle; req_done[0] pulses in cycle 4 after valid; req_rdata[7:0]=0x5A.
- Req1 TX 0xC3; STATUS returns 0x00 three times then 0x40 -> 4 polls at address 8, then write@4 with writedata=0x000000C3; req_done[1]=1 once.
- Both valid continuously, both ready immediately -> grants alternate 0,1,0,1 over 4 completions; no cycle has read and write both high.
- Req0 RX with STATUS stuck at 0x00, req1 TX with TX_OK set, POLL_LIMIT=16 -> after 16 polls req0 is parked, req1 completes, then req0 is re-polled; when RX_OK rises, req0 completes.
- waitrequest held high for 5 cycles during DATA write -> avm_write, address 4 and writedata stay stable for all 5 cycles; done pulses one cycle after waitrequest falls.
- avm_rst asserted while in DATA -> next edge all outputs are at reset values (read=0, write=0, address=8, grant=0); after release, a new request from req1 is granted first if rr_ptr reset to 0 and req0 is idle.
